// File: rtl/thermogrow_pkg.sv
// Shared constants for the thermogrow sensor path: clock rate, DHT11 timing
// defaults and the poll scheduler state encoding.
package thermogrow_pkg;

    localparam int CLK_HZ = 50_000_000;

    // The DHT11 must not be polled more often than once per second.
    localparam int DHT11_MIN_POLL_CYCLES = CLK_HZ;

    localparam int DEF_POLL_CYCLES    = 2 * CLK_HZ;
    localparam int DEF_TIMEOUT_CYCLES = CLK_HZ / 20;
    localparam int DEF_RETRY_CYCLES   = CLK_HZ / 10;
    localparam int DEF_MAX_ATTEMPTS   = 3;

    localparam logic [2:0] ST_IDLE_ENC        = 3'd0;
    localparam logic [2:0] ST_START_ENC       = 3'd1;
    localparam logic [2:0] ST_WAIT_RESP_ENC   = 3'd2;
    localparam logic [2:0] ST_BACKOFF_ENC     = 3'd3;
    localparam logic [2:0] ST_WAIT_PERIOD_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE        = ST_IDLE_ENC,
        ST_START       = ST_START_ENC,
        ST_WAIT_RESP   = ST_WAIT_RESP_ENC,
        ST_BACKOFF     = ST_BACKOFF_ENC,
        ST_WAIT_PERIOD = ST_WAIT_PERIOD_ENC
    } poll_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/thermo_interval_timer.sv
// Up-counter with synchronous clear and a terminal-count compare, shared by
// every timed state of the poll scheduler.
module thermo_interval_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Count from zero after each clear; saturate so an indefinite stay never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (count_r != {WIDTH{1'b1}}) begin
            count_r <= count_r + WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == terminal);

endmodule

// File: rtl/sensor_poll_scheduler.sv
// DHT11 poll scheduler: periodic read requests, response timeout, retry with
// backoff, and latching of validated temperature/humidity readings.
module sensor_poll_scheduler
    import thermogrow_pkg::*;
#(
    parameter int POLL_CYCLES    = DEF_POLL_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RETRY_CYCLES   = DEF_RETRY_CYCLES,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       force_poll,
    output logic       rd_start,
    input  logic       rd_done,
    input  logic       rd_err,
    input  logic [7:0] rd_temp,
    input  logic [7:0] rd_hum,
    output logic [7:0] temperature,
    output logic [7:0] humidity,
    output logic       data_valid,
    output logic       update,
    output logic       sensor_fault,
    output logic [3:0] attempt
);

    localparam int MAX_CYC = max3(POLL_CYCLES, TIMEOUT_CYCLES, RETRY_CYCLES);
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] TC_POLL    = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TC_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TC_RETRY   = TIMER_W'(RETRY_CYCLES - 1);
    localparam logic [3:0]         MAX_ATT    = 4'(MAX_ATTEMPTS);

    poll_state_t        state_r;
    poll_state_t        state_nxt_s;
    logic [TIMER_W-1:0] tc_s;
    logic               tmr_clr_s;
    logic               tmr_done_s;

    logic       rd_start_r, rd_start_nxt_s;
    logic [7:0] temp_r, temp_nxt_s;
    logic [7:0] hum_r, hum_nxt_s;
    logic       valid_r, valid_nxt_s;
    logic       update_r, update_nxt_s;
    logic       fault_r, fault_nxt_s;
    logic [3:0] attempt_r, attempt_nxt_s;

    // Terminal count for the state currently being timed.
    always_comb begin
        tc_s = {TIMER_W{1'b0}};
        case (state_r)
            ST_WAIT_RESP:   tc_s = TC_TIMEOUT;
            ST_BACKOFF:     tc_s = TC_RETRY;
            ST_WAIT_PERIOD: tc_s = TC_POLL;
            default:        tc_s = {TIMER_W{1'b0}};
        endcase
    end

    // The timer restarts from zero on every state entry.
    assign tmr_clr_s = (state_nxt_s != state_r);

    thermo_interval_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clr_s),
        .terminal (tc_s),
        .done     (tmr_done_s)
    );

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nxt_s   = state_r;
        temp_nxt_s    = temp_r;
        hum_nxt_s     = hum_r;
        valid_nxt_s   = valid_r;
        update_nxt_s  = 1'b0;
        fault_nxt_s   = fault_r;
        attempt_nxt_s = attempt_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s   = ST_START;
                    attempt_nxt_s = 4'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // An error wins over a simultaneous done; a silent reader times out.
                if (rd_err || (tmr_done_s && !rd_done)) begin
                    if (attempt_r < MAX_ATT) begin
                        state_nxt_s = enable ? ST_BACKOFF : ST_IDLE;
                    end else begin
                        fault_nxt_s = 1'b1;
                        state_nxt_s = enable ? ST_WAIT_PERIOD : ST_IDLE;
                    end
                end else if (rd_done) begin
                    temp_nxt_s    = rd_temp;
                    hum_nxt_s     = rd_hum;
                    valid_nxt_s   = 1'b1;
                    update_nxt_s  = 1'b1;
                    fault_nxt_s   = 1'b0;
                    attempt_nxt_s = 4'd0;
                    state_nxt_s   = enable ? ST_WAIT_PERIOD : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_RESP;
                end
            end
            ST_BACKOFF: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmr_done_s) begin
                    state_nxt_s   = ST_START;
                    attempt_nxt_s = attempt_r + 4'd1;
                end else begin
                    state_nxt_s = ST_BACKOFF;
                end
            end
            ST_WAIT_PERIOD: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmr_done_s || force_poll) begin
                    state_nxt_s   = ST_START;
                    attempt_nxt_s = 4'd1;
                end else begin
                    state_nxt_s = ST_WAIT_PERIOD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        rd_start_nxt_s = (state_nxt_s == ST_START);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rd_start_r <= 1'b0;
            temp_r     <= 8'd0;
            hum_r      <= 8'd0;
            valid_r    <= 1'b0;
            update_r   <= 1'b0;
            fault_r    <= 1'b0;
            attempt_r  <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            rd_start_r <= rd_start_nxt_s;
            temp_r     <= temp_nxt_s;
            hum_r      <= hum_nxt_s;
            valid_r    <= valid_nxt_s;
            update_r   <= update_nxt_s;
            fault_r    <= fault_nxt_s;
            attempt_r  <= attempt_nxt_s;
        end
    end

    assign rd_start     = rd_start_r;
    assign temperature  = temp_r;
    assign humidity     = hum_r;
    assign data_valid   = valid_r;
    assign update       = update_r;
    assign sensor_fault = fault_r;
    assign attempt      = attempt_r;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Self-checking bench for sensor_poll_scheduler: a table of per-poll vectors
// plus hand-written sequences for force_poll, enable drop and mid-read reset.
module tb_sensor_poll_scheduler;

    localparam int POLL = 100;
    localparam int TMO  = 20;
    localparam int RTY  = 5;
    localparam int MAXA = 3;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       force_poll;
    logic       rd_start;
    logic       rd_done;
    logic       rd_err;
    logic [7:0] rd_temp;
    logic [7:0] rd_hum;
    logic [7:0] temperature;
    logic [7:0] humidity;
    logic       data_valid;
    logic       update;
    logic       sensor_fault;
    logic [3:0] attempt;

    int checks = 0;
    int errors = 0;

    // One record per poll attempt, starting from the cycle rd_start is seen.
    typedef struct {
        int         kind;
        logic [7:0] t_in;
        logic [7:0] h_in;
        logic [7:0] t_exp;
        logic [7:0] h_exp;
        logic       valid;
        logic       fault;
        logic       upd;
        logic [3:0] att_start;
        logic [3:0] att_exp;
        int         wait_n;
    } vec_t;

    vec_t tbl [8];

    sensor_poll_scheduler #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO),
        .RETRY_CYCLES   (RTY),
        .MAX_ATTEMPTS   (MAXA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .force_poll   (force_poll),
        .rd_start     (rd_start),
        .rd_done      (rd_done),
        .rd_err       (rd_err),
        .rd_temp      (rd_temp),
        .rd_hum       (rd_hum),
        .temperature  (temperature),
        .humidity     (humidity),
        .data_valid   (data_valid),
        .update       (update),
        .sensor_fault (sensor_fault),
        .attempt      (attempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Tick until rd_start is seen; n = ticks taken, upd = update pulses seen on the way.
    task automatic wait_start(input int limit, output int n, output int upd);
        bit found;
        n = 0;
        upd = 0;
        found = 1'b0;
        while (!found && n < limit) begin
            tick();
            n++;
            if (update) upd++;
            if (rd_start) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_start: no rd_start within %0d cycles", limit);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_start"}, rd_start, 0);
        chk({tag, "_temperature"}, temperature, 0);
        chk({tag, "_humidity"}, humidity, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_update"}, update, 0);
        chk({tag, "_sensor_fault"}, sensor_fault, 0);
        chk({tag, "_attempt"}, attempt, 0);
    endtask

    initial begin
        int n;
        int u;
        int starts;

        rst        = 1'b0;
        enable     = 1'b1;
        force_poll = 1'b0;
        rd_done    = 1'b0;
        rd_err     = 1'b0;
        rd_temp    = 8'd0;
        rd_hum     = 8'd0;

        //            kind    t_in   h_in   t_exp  h_exp  val   flt   upd   a_st  a_exp wait
        tbl[0] = '{K_DONE, 8'd25, 8'd60, 8'd25, 8'd60, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, POLL};
        tbl[1] = '{K_ERR,  8'd0,  8'd0,  8'd25, 8'd60, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, RTY};
        tbl[2] = '{K_ERR,  8'd0,  8'd0,  8'd25, 8'd60, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, RTY};
        tbl[3] = '{K_ERR,  8'd0,  8'd0,  8'd25, 8'd60, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, POLL};
        tbl[4] = '{K_NONE, 8'd0,  8'd0,  8'd25, 8'd60, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, RTY};
        tbl[5] = '{K_DONE, 8'd30, 8'd55, 8'd30, 8'd55, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, POLL};
        tbl[6] = '{K_BOTH, 8'd40, 8'd70, 8'd30, 8'd55, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, RTY};
        tbl[7] = '{K_DONE, 8'd22, 8'd45, 8'd22, 8'd45, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, POLL};

        // Reset held for two edges with enable already high.
        tick();
        chk_all_zero("reset1");
        tick();
        chk_all_zero("reset2");
        rst = 1'b1;
        wait_start(10, n, u);
        chk("reset_to_start_gap", n + 1, 2);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_attempt_at_start", i), attempt, tbl[i].att_start);
            tick();
            chk($sformatf("v%0d_start_width", i), rd_start, 0);
            if (tbl[i].kind == K_NONE) begin
                repeat (TMO) tick();
            end else begin
                rd_temp = tbl[i].t_in;
                rd_hum  = tbl[i].h_in;
                rd_done = (tbl[i].kind != K_ERR);
                rd_err  = (tbl[i].kind != K_DONE);
                tick();
                rd_done = 1'b0;
                rd_err  = 1'b0;
            end
            chk($sformatf("v%0d_temperature", i), temperature, tbl[i].t_exp);
            chk($sformatf("v%0d_humidity", i), humidity, tbl[i].h_exp);
            chk($sformatf("v%0d_data_valid", i), data_valid, tbl[i].valid);
            chk($sformatf("v%0d_sensor_fault", i), sensor_fault, tbl[i].fault);
            chk($sformatf("v%0d_attempt", i), attempt, tbl[i].att_exp);
            chk($sformatf("v%0d_update", i), update, tbl[i].upd);
            wait_start(300, n, u);
            chk($sformatf("v%0d_cycles_to_next_start", i), n, tbl[i].wait_n);
            chk($sformatf("v%0d_update_pulses_while_waiting", i), u, 0);
        end

        // force_poll in WAIT_RESP is dropped; in WAIT_PERIOD it starts a poll at once.
        tick();
        force_poll = 1'b1;
        tick();
        force_poll = 1'b0;
        chk("fp_in_wait_resp_ignored", rd_start, 0);
        rd_temp = 8'd21;
        rd_hum  = 8'd50;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("fp_read_temperature", temperature, 21);
        starts = 0;
        repeat (10) begin
            tick();
            if (rd_start) starts++;
        end
        chk("fp_not_queued", starts, 0);
        force_poll = 1'b1;
        tick();
        force_poll = 1'b0;
        chk("fp_in_wait_period_start", rd_start, 1);
        chk("fp_attempt", attempt, 1);

        // enable dropped mid-read: the read still completes, then the block idles.
        tick();
        enable = 1'b0;
        tick();
        rd_temp = 8'd18;
        rd_hum  = 8'd40;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("en_drop_temperature", temperature, 18);
        chk("en_drop_humidity", humidity, 40);
        chk("en_drop_update", update, 1);
        starts = 0;
        for (int k = 0; k < 150; k++) begin
            if (k == 50) begin
                rd_temp = 8'd99;
                rd_done = 1'b1;
            end
            tick();
            rd_done = 1'b0;
            if (rd_start) starts++;
        end
        chk("idle_no_start", starts, 0);
        chk("idle_stray_done_ignored", temperature, 18);
        chk("idle_data_valid_held", data_valid, 1);

        // Re-enable, then reset in the middle of WAIT_RESP.
        enable = 1'b1;
        wait_start(10, n, u);
        chk("reenable_cycles_to_start", n, 1);
        chk("reenable_attempt", attempt, 1);
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("midread_reset");
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
